// File: rtl/cnn_core_mac_pkg.sv
// Shared constants and arithmetic helpers for the CNN MAC pipeline.
// Provides the default widths and the rounding/saturation functions.
// All helpers work on a 64-bit signed container, so ACC_WIDTH can be at most MAX_W.
package cnn_core_mac_pkg;

  localparam int unsigned DEF_DIN0_WIDTH = 12;
  localparam int unsigned DEF_DIN1_WIDTH = 8;
  localparam int unsigned DEF_ACC_WIDTH  = 32;
  localparam int unsigned DEF_DOUT_WIDTH = 16;
  localparam int unsigned DEF_NUM_STAGE  = 2;
  localparam int unsigned DEF_SHIFT      = 0;

  localparam int unsigned MAX_W = 64;

  typedef logic signed [MAX_W-1:0] wide_t;

  // Round half up, then arithmetic shift right. With shift == 0 no rounding term is added.
  function automatic wide_t round_shift(input wide_t v, input int unsigned shift);
    wide_t r;
    r = v;
    if (shift != 0) r = v + (wide_t'(1) <<< (shift - 1));
    return r >>> shift;
  endfunction

  // Clip v to the signed range of a w-bit value.
  function automatic wide_t sat_value(input wide_t v, input int unsigned w);
    wide_t hi;
    wide_t lo;
    hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    lo = -(wide_t'(1) <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // High when v lies outside the signed range of a w-bit value.
  function automatic logic sat_clip(input wide_t v, input int unsigned w);
    wide_t hi;
    wide_t lo;
    hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    lo = -(wide_t'(1) <<< (w - 1));
    return (v > hi) || (v < lo);
  endfunction

endpackage

// File: rtl/cnn_core_mac_pipe_if.sv
// Beat input and result output streams of the MAC pipeline.
// master: producer of beats / consumer of results. slave: the MAC pipeline.
interface cnn_core_mac_pipe_if
  import cnn_core_mac_pkg::*;
#(
  parameter int unsigned DIN0_WIDTH = DEF_DIN0_WIDTH,
  parameter int unsigned DIN1_WIDTH = DEF_DIN1_WIDTH,
  parameter int unsigned DOUT_WIDTH = DEF_DOUT_WIDTH
);

  logic                         in_valid;
  logic                         in_ready;
  logic signed [DIN0_WIDTH-1:0] din0;
  logic signed [DIN1_WIDTH-1:0] din1;
  logic                         in_last;
  logic                         out_valid;
  logic                         out_ready;
  logic signed [DOUT_WIDTH-1:0] dout;
  logic                         out_sat;

  modport master (
    output in_valid, din0, din1, in_last, out_ready,
    input  in_ready, out_valid, dout, out_sat
  );

  modport slave (
    input  in_valid, din0, din1, in_last, out_ready,
    output in_ready, out_valid, dout, out_sat
  );

endinterface

// File: rtl/cnn_core_mac_mul.sv
// NUM_STAGE-deep signed multiplier chain carrying valid and last alongside the product.
// Ports: clk, rst_n (sync, active low), ce (advance enable), in_valid/in_last/din0/din1 (beat in),
//        out_valid/out_last/prod (beat out after NUM_STAGE enabled edges).
module cnn_core_mac_mul #(
  parameter int unsigned DIN0_WIDTH = 12,
  parameter int unsigned DIN1_WIDTH = 8,
  parameter int unsigned NUM_STAGE  = 2
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  ce,
  input  logic                                  in_valid,
  input  logic                                  in_last,
  input  logic signed [DIN0_WIDTH-1:0]          din0,
  input  logic signed [DIN1_WIDTH-1:0]          din1,
  output logic                                  out_valid,
  output logic                                  out_last,
  output logic signed [DIN0_WIDTH+DIN1_WIDTH-1:0] prod
);

  localparam int unsigned PW = DIN0_WIDTH + DIN1_WIDTH;

  logic [NUM_STAGE-1:0]  vld_q;
  logic [NUM_STAGE-1:0]  last_q;
  logic signed [PW-1:0]  prod_q [NUM_STAGE];

  // Valid chain: the only state that must be cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= '0;
    end else if (ce) begin
      vld_q[0] <= in_valid;
      for (int i = 1; i < NUM_STAGE; i++) vld_q[i] <= vld_q[i-1];
    end
  end

  // Data chain: product formed at full precision in the first stage.
  always_ff @(posedge clk) begin
    if (ce) begin
      prod_q[0] <= PW'(din0) * PW'(din1);
      last_q[0] <= in_last;
      for (int i = 1; i < NUM_STAGE; i++) begin
        prod_q[i] <= prod_q[i-1];
        last_q[i] <= last_q[i-1];
      end
    end
  end

  assign out_valid = vld_q[NUM_STAGE-1];
  assign out_last  = last_q[NUM_STAGE-1];
  assign prod      = prod_q[NUM_STAGE-1];

endmodule

// File: rtl/cnn_core_mac_pipe.sv
// Pipelined signed multiply-accumulate with rounding, saturation and valid/ready handshake.
// Ports: ap_clk, ap_rst_n (sync, active low), bus (slave modport):
//   in_valid/in_ready/din0/din1/in_last beat input, out_valid/out_ready/dout/out_sat result output.
module cnn_core_mac_pipe
  import cnn_core_mac_pkg::*;
#(
  parameter int unsigned ID         = 1,
  parameter int unsigned DIN0_WIDTH = DEF_DIN0_WIDTH,
  parameter int unsigned DIN1_WIDTH = DEF_DIN1_WIDTH,
  parameter int unsigned ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int unsigned DOUT_WIDTH = DEF_DOUT_WIDTH,
  parameter int unsigned NUM_STAGE  = DEF_NUM_STAGE,
  parameter int unsigned SHIFT      = DEF_SHIFT
) (
  input  logic                ap_clk,
  input  logic                ap_rst_n,
  cnn_core_mac_pipe_if.slave  bus
);

  localparam int unsigned PW = DIN0_WIDTH + DIN1_WIDTH;

  // Elaboration-time parameter sanity checks.
  if (ACC_WIDTH < PW || ACC_WIDTH > MAX_W) begin : g_bad_acc
    $error("cnn_core_mac_pipe %0d: ACC_WIDTH out of range", ID);
  end
  if (DOUT_WIDTH > ACC_WIDTH || NUM_STAGE < 1 || SHIFT >= ACC_WIDTH) begin : g_bad_cfg
    $error("cnn_core_mac_pipe %0d: bad DOUT_WIDTH/NUM_STAGE/SHIFT", ID);
  end

  logic                         stall_c;
  logic                         mul_valid;
  logic                         mul_last;
  logic signed [PW-1:0]         mul_prod;
  logic signed [ACC_WIDTH-1:0]  acc_q;
  logic signed [ACC_WIDTH-1:0]  acc_sum;
  wide_t                        rnd;
  logic signed [DOUT_WIDTH-1:0] dout_d;
  logic                         sat_d;
  logic                         out_valid_q;
  logic signed [DOUT_WIDTH-1:0] dout_q;
  logic                         out_sat_q;

  // A held result that is not being taken freezes the whole pipeline.
  assign stall_c = out_valid_q & ~bus.out_ready;

  cnn_core_mac_mul #(
    .DIN0_WIDTH (DIN0_WIDTH),
    .DIN1_WIDTH (DIN1_WIDTH),
    .NUM_STAGE  (NUM_STAGE)
  ) u_mul (
    .clk       (ap_clk),
    .rst_n     (ap_rst_n),
    .ce        (~stall_c),
    .in_valid  (bus.in_valid),
    .in_last   (bus.in_last),
    .din0      (bus.din0),
    .din1      (bus.din1),
    .out_valid (mul_valid),
    .out_last  (mul_last),
    .prod      (mul_prod)
  );

  // Accumulate (wrapping), then round, shift and clip the candidate result.
  always_comb begin
    acc_sum = acc_q + ACC_WIDTH'(mul_prod);
    rnd     = round_shift(MAX_W'(acc_sum), SHIFT);
    dout_d  = DOUT_WIDTH'(sat_value(rnd, DOUT_WIDTH));
    sat_d   = sat_clip(rnd, DOUT_WIDTH);
  end

  // Accumulator restarts from zero after each last beat; output register reloads on a last beat.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      out_sat_q   <= 1'b0;
    end else if (!stall_c) begin
      if (mul_valid) acc_q <= mul_last ? '0 : acc_sum;
      out_valid_q <= mul_valid & mul_last;
      if (mul_valid && mul_last) begin
        dout_q    <= dout_d;
        out_sat_q <= sat_d;
      end
    end
  end

  assign bus.in_ready  = ~stall_c;
  assign bus.out_valid = out_valid_q;
  assign bus.dout      = dout_q;
  assign bus.out_sat   = out_sat_q;

endmodule
